dht11_response_builder: RTL and testbench

- Sits between the UART command receiver and the UART transmitter, next to `DHT11Communication`.
- Accepts one request (command byte), then starts one DHT11 measurement through the communication block's `enable`/`reset` inputs and waits for completion or error.
- Validates the 40-bit frame checksum and emits a two-byte response (code, data) on a valid/ready byte stream toward the transmitter.

---
 rtl/dht_cmd_pkg.sv | 39 +++
 rtl/dht11_checksum_check.sv | 18 +
 rtl/dht11_response_builder.sv | 149 ++++++++++++++
 tb/tb_dht11_response_builder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dht_cmd_pkg.sv
// Shared command/response encodings and FSM states for the DHT11 response builder.
package dht_cmd_pkg;

  localparam logic [7:0] CMD_STATUS    = 8'h00;
  localparam logic [7:0] CMD_READ_TEMP = 8'h01;
  localparam logic [7:0] CMD_READ_HUM  = 8'h02;

  localparam logic [7:0] RSP_OK           = 8'h07;
  localparam logic [7:0] RSP_HUM          = 8'h08;
  localparam logic [7:0] RSP_TEMP         = 8'h09;
  localparam logic [7:0] RSP_SENSOR_ERR   = 8'h1F;
  localparam logic [7:0] RSP_CHECKSUM_ERR = 8'h2F;
  localparam logic [7:0] RSP_TIMEOUT      = 8'h3F;
  localparam logic [7:0] RSP_INVALID      = 8'hEF;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100_000_000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_CHECK     = 3'd3,
    ST_SEND_CODE = 3'd4,
    ST_SEND_DATA = 3'd5
  } state_t;

  function automatic logic is_valid_cmd(input logic [7:0] cmd);
    return (cmd == CMD_STATUS) || (cmd == CMD_READ_TEMP) || (cmd == CMD_READ_HUM);
  endfunction

  function automatic logic [7:0] success_code(input logic [7:0] cmd);
    case (cmd)
      CMD_READ_TEMP: return RSP_TEMP;
      CMD_READ_HUM:  return RSP_HUM;
      default:       return RSP_OK;
    endcase
  endfunction

endpackage

// File: rtl/dht11_checksum_check.sv
// Combinational DHT11 frame checksum test: low byte of the four-byte sum must equal checksum.
module dht11_checksum_check (
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_float,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_float,
  input  logic [7:0] checksum,
  output logic       ok
);

  logic [9:0] sum;

  always_comb begin
    sum = {2'b00, hum_int} + {2'b00, hum_float} + {2'b00, temp_int} + {2'b00, temp_float};
    ok  = (sum[7:0] == checksum);
  end

endmodule

// File: rtl/dht11_response_builder.sv
// Runs one DHT11 measurement per command and returns a (code, data) byte pair to the UART TX.
module dht11_response_builder
  import dht_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_command,
  output logic       busy,
  output logic [7:0] sensor_enable,
  output logic       sensor_reset,
  input  logic [7:0] sensor_hum_int,
  input  logic [7:0] sensor_hum_float,
  input  logic [7:0] sensor_temp_int,
  input  logic [7:0] sensor_temp_float,
  input  logic [7:0] sensor_checksum,
  input  logic       sensor_done,
  input  logic       sensor_error,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
);

  localparam logic [26:0] TIMEOUT_LAST = 27'(TIMEOUT_CYCLES - 1);
  localparam logic [26:0] HOLDOFF      = 27'd2;

  state_t      state, state_next;
  logic [7:0]  cmd, code, data;
  logic [26:0] wait_cnt;
  logic        err_smp;
  logic [7:0]  f_hum_int, f_hum_float, f_temp_int, f_temp_float, f_checksum;
  logic        sum_ok;
  logic        done_accept, timed_out;

  dht11_checksum_check u_checksum (
    .hum_int    (f_hum_int),
    .hum_float  (f_hum_float),
    .temp_int   (f_temp_int),
    .temp_float (f_temp_float),
    .checksum   (f_checksum),
    .ok         (sum_ok)
  );

  // Done is only trusted once the holdoff has elapsed; it wins over a coincident timeout.
  assign done_accept = (state == ST_WAIT) && (wait_cnt >= HOLDOFF) && sensor_done;
  assign timed_out   = (state == ST_WAIT) && !done_accept && (wait_cnt >= TIMEOUT_LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b1;
    sensor_enable = 8'h00;
    sensor_reset  = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (req_valid) state_next = is_valid_cmd(req_command) ? ST_START : ST_SEND_CODE;
      end
      ST_START: begin
        sensor_enable = 8'h01;
        sensor_reset  = 1'b1;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        sensor_enable = 8'h01;
        if (done_accept)    state_next = ST_CHECK;
        else if (timed_out) state_next = ST_SEND_CODE;
      end
      ST_CHECK: state_next = ST_SEND_CODE;
      ST_SEND_CODE: begin
        tx_valid = 1'b1;
        tx_data  = code;
        if (tx_ready) state_next = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data;
        if (tx_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd          <= '0;
      code         <= '0;
      data         <= '0;
      wait_cnt     <= '0;
      err_smp      <= 1'b0;
      f_hum_int    <= '0;
      f_hum_float  <= '0;
      f_temp_int   <= '0;
      f_temp_float <= '0;
      f_checksum   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cmd  <= req_command;
            data <= '0;
            if (!is_valid_cmd(req_command)) code <= RSP_INVALID;
          end
        end
        ST_START: wait_cnt <= '0;
        ST_WAIT: begin
          if (wait_cnt != '1) wait_cnt <= wait_cnt + 27'd1;
          if (done_accept) begin
            err_smp      <= sensor_error;
            f_hum_int    <= sensor_hum_int;
            f_hum_float  <= sensor_hum_float;
            f_temp_int   <= sensor_temp_int;
            f_temp_float <= sensor_temp_float;
            f_checksum   <= sensor_checksum;
          end else if (timed_out) begin
            code <= RSP_TIMEOUT;
            data <= '0;
          end
        end
        ST_CHECK: begin
          if (err_smp) begin
            code <= RSP_SENSOR_ERR;
            data <= '0;
          end else if (!sum_ok) begin
            code <= RSP_CHECKSUM_ERR;
            data <= '0;
          end else begin
            code <= success_code(cmd);
            case (cmd)
              CMD_READ_TEMP: data <= f_temp_int;
              CMD_READ_HUM:  data <= f_hum_int;
              default:       data <= '0;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_response_builder.sv
// Directed self-checking bench for dht11_response_builder (TIMEOUT_CYCLES reduced to 100).
module tb_dht11_response_builder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_command = 8'h00;
  logic       busy;
  logic [7:0] sensor_enable;
  logic       sensor_reset;
  logic [7:0] sensor_hum_int = 8'd35, sensor_hum_float = 8'd0;
  logic [7:0] sensor_temp_int = 8'd24, sensor_temp_float = 8'd0;
  logic [7:0] sensor_checksum = 8'd59;
  logic       sensor_done = 1'b0, sensor_error = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dht11_response_builder #(.TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_command(req_command),
    .busy(busy), .sensor_enable(sensor_enable), .sensor_reset(sensor_reset),
    .sensor_hum_int(sensor_hum_int), .sensor_hum_float(sensor_hum_float),
    .sensor_temp_int(sensor_temp_int), .sensor_temp_float(sensor_temp_float),
    .sensor_checksum(sensor_checksum), .sensor_done(sensor_done), .sensor_error(sensor_error),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_request(input logic [7:0] c);
    req_valid   = 1'b1;
    req_command = c;
    step();
    req_valid   = 1'b0;
  endtask

  // Drains up to two response bytes with tx_ready high; ok=0 if the budget expires.
  task automatic collect(output logic [7:0] b0, output logic [7:0] b1, output bit ok);
    int n = 0;
    b0 = 8'hxx;
    b1 = 8'hxx;
    tx_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (tx_valid) begin
        if (n == 0) b0 = tx_data;
        else        b1 = tx_data;
        n++;
      end
      step();
      if (n == 2) break;
    end
    ok = (n == 2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    vectors++; if (sensor_enable !== 8'h00) begin miscompares++; $display("FAIL reset_enable got %h want 00", sensor_enable); end
    vectors++; if (sensor_reset !== 1'b0) begin miscompares++; $display("FAIL reset_sensor_reset got %0b want 0", sensor_reset); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_temp();
    sensor_checksum = 8'd59;
    tx_ready = 1'b1;
    do_request(8'h01);
    vectors++; if (busy !== 1'b1 || sensor_enable !== 8'h01 || sensor_reset !== 1'b1) begin
      miscompares++; $display("FAIL temp_start got busy=%0b en=%h rst=%0b want 1 01 1", busy, sensor_enable, sensor_reset); end
    step();
    vectors++; if (sensor_enable !== 8'h01 || sensor_reset !== 1'b0) begin
      miscompares++; $display("FAIL temp_wait1 got en=%h rst=%0b want 01 0", sensor_enable, sensor_reset); end
    sensor_done = 1'b1;
    step();
    vectors++; if (sensor_enable !== 8'h01) begin miscompares++; $display("FAIL temp_holdoff2 got en=%h want 01", sensor_enable); end
    step();
    vectors++; if (sensor_enable !== 8'h01) begin miscompares++; $display("FAIL temp_wait3 got en=%h want 01", sensor_enable); end
    step();
    vectors++; if (sensor_enable !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL temp_check got en=%h txv=%0b busy=%0b want 00 0 1", sensor_enable, tx_valid, busy); end
    sensor_done = 1'b0;
    step();
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h09) begin
      miscompares++; $display("FAIL temp_code got v=%0b d=%h want 1 09", tx_valid, tx_data); end
    step();
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h18) begin
      miscompares++; $display("FAIL temp_data got v=%0b d=%h want 1 18", tx_valid, tx_data); end
    step();
    vectors++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++; $display("FAIL temp_done got busy=%0b txv=%0b want 0 0", busy, tx_valid); end
  endtask

  task automatic test_hum_bad_checksum();
    logic [7:0] b0, b1;
    bit ok;
    sensor_checksum = 8'd60;
    do_request(8'h02);
    sensor_done = 1'b1;
    collect(b0, b1, ok);
    sensor_done = 1'b0;
    sensor_checksum = 8'd59;
    vectors++; if (!ok || b0 !== 8'h2F || b1 !== 8'h00) begin
      miscompares++; $display("FAIL hum_badsum got ok=%0b %h %h want 1 2f 00", ok, b0, b1); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hum_badsum_busy got %0b want 0", busy); end
  endtask

  task automatic test_sensor_error();
    logic [7:0] b0, b1;
    bit ok;
    do_request(8'h00);
    sensor_done  = 1'b1;
    sensor_error = 1'b1;
    collect(b0, b1, ok);
    sensor_done  = 1'b0;
    sensor_error = 1'b0;
    vectors++; if (!ok || b0 !== 8'h1F || b1 !== 8'h00) begin
      miscompares++; $display("FAIL sensor_err got ok=%0b %h %h want 1 1f 00", ok, b0, b1); end
    do_request(8'h00);
    step();
    sensor_error = 1'b1;
    repeat (10) step();
    vectors++; if (sensor_enable !== 8'h01 || tx_valid !== 1'b0) begin
      miscompares++; $display("FAIL transient_err_wait got en=%h txv=%0b want 01 0", sensor_enable, tx_valid); end
    sensor_error = 1'b0;
    sensor_done  = 1'b1;
    collect(b0, b1, ok);
    sensor_done  = 1'b0;
    vectors++; if (!ok || b0 !== 8'h07 || b1 !== 8'h00) begin
      miscompares++; $display("FAIL transient_err got ok=%0b %h %h want 1 07 00", ok, b0, b1); end
  endtask

  task automatic test_invalid_backpressure();
    tx_ready = 1'b0;
    do_request(8'h5A);
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'hEF || busy !== 1'b1 || sensor_enable !== 8'h00) begin
      miscompares++; $display("FAIL invalid_first got v=%0b d=%h busy=%0b en=%h want 1 ef 1 00", tx_valid, tx_data, busy, sensor_enable); end
    for (int i = 0; i < 20; i++) begin
      req_valid   = (i == 5);
      req_command = 8'h01;
      step();
      vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'hEF || busy !== 1'b1 || sensor_enable !== 8'h00 || sensor_reset !== 1'b0) begin
        miscompares++; $display("FAIL invalid_hold[%0d] got v=%0b d=%h busy=%0b en=%h rst=%0b want 1 ef 1 00 0",
                                i, tx_valid, tx_data, busy, sensor_enable, sensor_reset); end
    end
    req_valid = 1'b0;
    tx_ready  = 1'b1;
    step();
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h00 || busy !== 1'b1) begin
      miscompares++; $display("FAIL invalid_data got v=%0b d=%h busy=%0b want 1 00 1", tx_valid, tx_data, busy); end
    step();
    vectors++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      miscompares++; $display("FAIL invalid_end got busy=%0b txv=%0b want 0 0", busy, tx_valid); end
    step();
    vectors++; if (busy !== 1'b0 || sensor_enable !== 8'h00) begin
      miscompares++; $display("FAIL invalid_no_queue got busy=%0b en=%h want 0 00", busy, sensor_enable); end
  endtask

  task automatic test_timeout();
    logic [7:0] b0, b1;
    bit ok;
    int wait_cycles = 0;
    bit saw_valid = 0;
    do_request(8'h01);
    for (int i = 0; i < 300; i++) begin
      if (tx_valid) begin saw_valid = 1; break; end
      if (sensor_enable == 8'h01 && sensor_reset == 1'b0) wait_cycles++;
      step();
    end
    vectors++; if (!saw_valid || wait_cycles != 100) begin
      miscompares++; $display("FAIL timeout_len got seen=%0b wait=%0d want 1 100", saw_valid, wait_cycles); end
    collect(b0, b1, ok);
    vectors++; if (!ok || b0 !== 8'h3F || b1 !== 8'h00) begin
      miscompares++; $display("FAIL timeout_bytes got ok=%0b %h %h want 1 3f 00", ok, b0, b1); end
  endtask

  task automatic test_reset_in_wait();
    logic [7:0] b0, b1;
    bit ok;
    do_request(8'h01);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (busy !== 1'b0 || sensor_enable !== 8'h00 || tx_valid !== 1'b0 || sensor_reset !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_wait got busy=%0b en=%h txv=%0b rst=%0b want 0 00 0 0", busy, sensor_enable, tx_valid, sensor_reset); end
    do_request(8'h02);
    sensor_done = 1'b1;
    collect(b0, b1, ok);
    sensor_done = 1'b0;
    vectors++; if (!ok || b0 !== 8'h08 || b1 !== 8'h23) begin
      miscompares++; $display("FAIL hum_after_reset got ok=%0b %h %h want 1 08 23", ok, b0, b1); end
  endtask

  initial begin
    test_reset();
    test_read_temp();
    test_hum_bad_checksum();
    test_sensor_error();
    test_invalid_backpressure();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
